// File: rtl/quotient_bcd_if.sv
// Handshake and result bundle between the divider side and the BCD converter.
// The converter takes the slave view; the requester/display side takes master.
interface quotient_bcd_if;
    logic        START;
    logic [15:0] inQ;
    logic [7:0]  inR;
    logic [2:0]  inFLAG;
    logic [19:0] qBCD;
    logic [11:0] rBCD;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    modport master (
        output START, inQ, inR, inFLAG,
        input  qBCD, rBCD, BUSY, DONE, ERR
    );

    modport slave (
        input  START, inQ, inR, inFLAG,
        output qBCD, rBCD, BUSY, DONE, ERR
    );
endinterface

// File: rtl/quotient_bcd.sv
// Sequential double-dabble converter: 16-bit quotient and 8-bit remainder to packed BCD,
// one shift-and-add-3 iteration per clock, with a one-cycle shortcut for divide-by-zero.
module quotient_bcd (
    input  logic          CLOCK,
    input  logic          RESET,
    quotient_bcd_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [15:0] q_sr_reg;
    logic [7:0]  r_sr_reg;
    logic [19:0] q_acc_reg;
    logic [11:0] r_acc_reg;
    logic [19:0] q_bcd_reg;
    logic [11:0] r_bcd_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;

    logic [19:0] q_adj;
    logic [11:0] r_adj;
    logic [19:0] q_acc_next;
    logic [11:0] r_acc_next;

    // Per-digit correction; digits never carry into each other.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_q_adj
            assign q_adj[gi*4 +: 4] = (q_acc_reg[gi*4 +: 4] >= 4'd5) ?
                                      q_acc_reg[gi*4 +: 4] + 4'd3 : q_acc_reg[gi*4 +: 4];
        end
        for (gi = 0; gi < 3; gi++) begin : g_r_adj
            assign r_adj[gi*4 +: 4] = (r_acc_reg[gi*4 +: 4] >= 4'd5) ?
                                      r_acc_reg[gi*4 +: 4] + 4'd3 : r_acc_reg[gi*4 +: 4];
        end
    endgenerate

    assign q_acc_next = {q_adj[18:0], q_sr_reg[15]};
    assign r_acc_next = {r_adj[10:0], r_sr_reg[7]};

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
            q_sr_reg  <= 16'd0;
            r_sr_reg  <= 8'd0;
            q_acc_reg <= 20'd0;
            r_acc_reg <= 12'd0;
            q_bcd_reg <= 20'd0;
            r_bcd_reg <= 12'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.START) begin
                        if (bus.inFLAG == 3'b011) begin
                            q_bcd_reg <= 20'hFFFFF;
                            r_bcd_reg <= 12'hFFF;
                            err_reg   <= 1'b1;
                            done_reg  <= 1'b1;
                        end else begin
                            q_sr_reg  <= bus.inQ;
                            r_sr_reg  <= bus.inR;
                            q_acc_reg <= 20'd0;
                            r_acc_reg <= 12'd0;
                            cnt_reg   <= 5'd0;
                            busy_reg  <= 1'b1;
                            state_reg <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    q_acc_reg <= q_acc_next;
                    q_sr_reg  <= {q_sr_reg[14:0], 1'b0};
                    // The remainder has only 8 bits to consume, then it freezes.
                    if (cnt_reg < 5'd8) begin
                        r_acc_reg <= r_acc_next;
                        r_sr_reg  <= {r_sr_reg[6:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd15) begin
                        q_bcd_reg <= q_acc_next;
                        r_bcd_reg <= r_acc_reg;
                        err_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.qBCD = q_bcd_reg;
    assign bus.rBCD = r_bcd_reg;
    assign bus.BUSY = busy_reg;
    assign bus.DONE = done_reg;
    assign bus.ERR  = err_reg;
endmodule
